// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment digit scanner with a frame-synchronous display
// register and a one-deep pending slot so updates never tear mid-frame.
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*NUM_DIGITS-1:0]   in_value,
    input  logic [NUM_DIGITS-1:0]     in_dp,
    input  logic                      in_blank_lz,
    output logic [3:0]                digit_num,
    output logic                      digit_blank,
    output logic [NUM_DIGITS-1:0]     anode_n,
    output logic                      dp_n,
    output logic                      frame_done
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  active_q, active_d;
    logic [DW-1:0]         disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic                  disp_lz_q, disp_lz_d;
    logic [DW-1:0]         pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_lz_q, pend_lz_d;
    logic                  pend_full_q, pend_full_d;
    logic                  in_ready_q, in_ready_d;
    logic [NUM_DIGITS-1:0] anode_n_q, anode_n_d;
    logic [3:0]            digit_num_q, digit_num_d;
    logic                  digit_blank_q, digit_blank_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick, boundary, accept;
    logic                  upper_nonzero;
    logic [3:0]            sel_num;
    logic                  sel_dp, sel_blank;

    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        boundary = tick && (idx_q == IDX_LAST);
        accept   = in_valid && in_ready_q;

        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        active_d = active_q || tick;

        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        disp_lz_d   = disp_lz_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_lz_d   = pend_lz_q;
        pend_full_d = pend_full_q;

        // The display register only ever changes on a frame boundary.
        if (boundary && pend_full_q) begin
            disp_val_d  = pend_val_q;
            disp_dp_d   = pend_dp_q;
            disp_lz_d   = pend_lz_q;
            pend_full_d = 1'b0;
        end else if (boundary && accept) begin
            disp_val_d = in_value;
            disp_dp_d  = in_dp;
            disp_lz_d  = in_blank_lz;
        end else if (accept) begin
            pend_val_d  = in_value;
            pend_dp_d   = in_dp;
            pend_lz_d   = in_blank_lz;
            pend_full_d = 1'b1;
        end

        in_ready_d   = !pend_full_d;
        frame_done_d = boundary;

        // Scan from the top digit down so each digit knows whether anything above it is nonzero.
        upper_nonzero = 1'b0;
        sel_num       = '0;
        sel_dp        = 1'b0;
        sel_blank     = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_nonzero = upper_nonzero | (disp_val_d[4*i +: 4] != 4'h0);
            if (IDX_W'(i) == idx_d) begin
                sel_num   = disp_val_d[4*i +: 4];
                sel_dp    = disp_dp_d[i];
                sel_blank = disp_lz_d && (i != 0) && !upper_nonzero;
            end
        end

        if (active_d) begin
            anode_n_d     = ~(NUM_DIGITS'(1) << idx_d);
            digit_num_d   = sel_num;
            digit_blank_d = sel_blank;
            dp_n_d        = sel_blank | ~sel_dp;
        end else begin
            anode_n_d     = '1;
            digit_num_d   = '0;
            digit_blank_d = 1'b1;
            dp_n_d        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= IDX_LAST;
            active_q      <= 1'b0;
            disp_val_q    <= '0;
            disp_dp_q     <= '0;
            disp_lz_q     <= 1'b0;
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pend_lz_q     <= 1'b0;
            pend_full_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            anode_n_q     <= '1;
            digit_num_q   <= '0;
            digit_blank_q <= 1'b1;
            dp_n_q        <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            disp_val_q    <= disp_val_d;
            disp_dp_q     <= disp_dp_d;
            disp_lz_q     <= disp_lz_d;
            pend_val_q    <= pend_val_d;
            pend_dp_q     <= pend_dp_d;
            pend_lz_q     <= pend_lz_d;
            pend_full_q   <= pend_full_d;
            in_ready_q    <= in_ready_d;
            anode_n_q     <= anode_n_d;
            digit_num_q   <= digit_num_d;
            digit_blank_q <= digit_blank_d;
            dp_n_q        <= dp_n_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign anode_n     = anode_n_q;
    assign digit_num   = digit_num_q;
    assign digit_blank = digit_blank_q;
    assign dp_n        = dp_n_q;
    assign frame_done  = frame_done_q;

endmodule
